// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared encodings for the memory request arbiter
// Purpose: FSM state and owner encodings plus the grant vector bit positions
//          used by mem_req_arbiter and mem_req_arbiter_pick.
// Ports: none (package).
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IR   = 2'd1,
    OWN_DR   = 2'd2,
    OWN_WB   = 2'd3
  } owner_t;

  // Bit positions inside the one-hot pick vector.
  localparam int PICK_IR = 0;
  localparam int PICK_DR = 1;
  localparam int PICK_WB = 2;

  // Instruction fetches are always full-word reads.
  localparam logic [1:0] IR_SIZE = 2'd2;

endpackage

// File: rtl/mem_req_arbiter_pick.sv
// rtl/mem_req_arbiter_pick.sv - combinational priority picker for the memory arbiter
// Purpose: chooses at most one requester per cycle, one-hot result.
// Ports:
//   ir_req, dr_req          requester strobes
//   wb_empty, wb_full       write buffer status
//   wb_related              buffered write matches the pending data read address
//   starve                  instruction fetch has waited STARVE_LIMIT idle cycles
//   pick[2:0]               one-hot {wb, dr, ir}
module mem_req_arbiter_pick
  import mem_req_arbiter_pkg::*;
(
  input  logic       ir_req,
  input  logic       dr_req,
  input  logic       wb_empty,
  input  logic       wb_full,
  input  logic       wb_related,
  input  logic       starve,
  output logic [2:0] pick
);

  always_comb begin
    pick = '0;
    if (starve && ir_req) begin
      pick[PICK_IR] = 1'b1;
    end else if (wb_full && !wb_empty) begin
      // A full buffer drains ahead of reads so store stalls stay bounded.
      pick[PICK_WB] = 1'b1;
    end else if (dr_req && !wb_related) begin
      pick[PICK_DR] = 1'b1;
    end else if (dr_req && wb_related) begin
      // Drain the older store first so the load observes it.
      pick[PICK_WB] = 1'b1;
    end else if (ir_req) begin
      pick[PICK_IR] = 1'b1;
    end else if (!wb_empty) begin
      pick[PICK_WB] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - three-way arbiter/sequencer for the shared memory request port
// Purpose: shares one SRAM-like port between instruction fetch (ir), data read (dr)
//          and write buffer drain (wb), one transaction outstanding at a time.
// Config macro: MEM_ARB_STARVE_GUARD_EN enables the instruction-fetch starvation guard.
// Ports:
//   clk, resetn                           clock, async active-low reset
//   ir_req/ir_addr/ir_gnt/ir_done         instruction read requester
//   dr_req/dr_addr/dr_size/dr_gnt/dr_done data read requester
//   wb_empty/wb_full/wb_related           write buffer status
//   wb_addr/wb_wdata/wb_wstrb/wb_size     write buffer head entry, wb_ren pops it
//   rdata                                 read data, valid with ir_done/dr_done
//   mem_*                                 memory request port
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ir_req,
  input  logic [ADDR_WIDTH-1:0] ir_addr,
  output logic                  ir_gnt,
  output logic                  ir_done,
  input  logic                  dr_req,
  input  logic [ADDR_WIDTH-1:0] dr_addr,
  input  logic [1:0]            dr_size,
  output logic                  dr_gnt,
  output logic                  dr_done,
  input  logic                  wb_empty,
  input  logic                  wb_full,
  input  logic                  wb_related,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  input  logic [3:0]            wb_wstrb,
  input  logic [1:0]            wb_size,
  output logic                  wb_ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [1:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t     state;
  owner_t     owner;
  logic [2:0] pick;
  logic       starve;
  logic       idle;
  logic       complete;

  assign idle = (state == ST_IDLE);

  // Completion: data_ok in WAIT, or addr_ok and data_ok together in REQ.
  assign complete = ((state == ST_REQ) && mem_addr_ok && mem_data_ok) ||
                    ((state == ST_WAIT) && mem_data_ok);

  mem_req_arbiter_pick u_pick (
    .ir_req    (ir_req),
    .dr_req    (dr_req),
    .wb_empty  (wb_empty),
    .wb_full   (wb_full),
    .wb_related(wb_related),
    .starve    (starve),
    .pick      (pick)
  );

  assign ir_gnt  = idle && pick[PICK_IR];
  assign dr_gnt  = idle && pick[PICK_DR];
  assign ir_done = complete && (owner == OWN_IR);
  assign dr_done = complete && (owner == OWN_DR);
  // The write buffer entry is only popped once the memory has accepted the data.
  assign wb_ren  = complete && (owner == OWN_WB);
  assign rdata   = (ir_done || dr_done) ? mem_rdata : '0;
  assign mem_req = (state == ST_REQ);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] starve_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (ir_gnt) begin
        starve_cnt <= '0;
      end else if (ir_req && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign starve = (starve_cnt == STARVE_MAX);
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      owner     <= OWN_NONE;
      mem_wr    <= 1'b0;
      mem_size  <= '0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick[PICK_IR]) begin
            state     <= ST_REQ;
            owner     <= OWN_IR;
            mem_wr    <= 1'b0;
            mem_size  <= IR_SIZE;
            mem_addr  <= ir_addr;
            mem_wstrb <= '0;
            mem_wdata <= '0;
          end else if (pick[PICK_DR]) begin
            state     <= ST_REQ;
            owner     <= OWN_DR;
            mem_wr    <= 1'b0;
            mem_size  <= dr_size;
            mem_addr  <= dr_addr;
            mem_wstrb <= '0;
            mem_wdata <= '0;
          end else if (pick[PICK_WB]) begin
            state     <= ST_REQ;
            owner     <= OWN_WB;
            mem_wr    <= 1'b1;
            mem_size  <= wb_size;
            mem_addr  <= wb_addr;
            mem_wstrb <= wb_wstrb;
            mem_wdata <= wb_wdata;
          end
        end
        ST_REQ, ST_WAIT: begin
          if (complete) begin
            // Clear the payload so mem_wr never lingers outside a WB transaction.
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            mem_wr    <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
          end else if ((state == ST_REQ) && mem_addr_ok) begin
            state <= ST_WAIT;
          end
        end
        default: begin
          state <= ST_IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ir_req, dr_req;
  logic [31:0] ir_addr, dr_addr;
  logic [1:0]  dr_size;
  logic        ir_gnt, ir_done, dr_gnt, dr_done;
  logic        wb_empty, wb_full, wb_related, wb_ren;
  logic [31:0] wb_addr, wb_wdata;
  logic [3:0]  wb_wstrb;
  logic [1:0]  wb_size;
  logic [31:0] rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(8), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ir_req(ir_req), .ir_addr(ir_addr), .ir_gnt(ir_gnt), .ir_done(ir_done),
    .dr_req(dr_req), .dr_addr(dr_addr), .dr_size(dr_size), .dr_gnt(dr_gnt), .dr_done(dr_done),
    .wb_empty(wb_empty), .wb_full(wb_full), .wb_related(wb_related),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wstrb(wb_wstrb), .wb_size(wb_size),
    .wb_ren(wb_ren), .rdata(rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  typedef struct {
    owner_t      who;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle in IDLE with requests applied: checks the grant and
  // records the transaction the memory port should carry next.
  task automatic arb_step(input owner_t who, input string tag);
    exp_t e;
    #1;
    chk({tag, ".ir_gnt"}, 32'(ir_gnt), 32'(who == OWN_IR));
    chk({tag, ".dr_gnt"}, 32'(dr_gnt), 32'(who == OWN_DR));
    e.who = who;
    case (who)
      OWN_IR:  begin e.wr = 1'b0; e.addr = ir_addr; e.wdata = '0; e.wstrb = '0; e.size = 2'd2; end
      OWN_DR:  begin e.wr = 1'b0; e.addr = dr_addr; e.wdata = '0; e.wstrb = '0; e.size = dr_size; end
      default: begin e.wr = 1'b1; e.addr = wb_addr; e.wdata = wb_wdata; e.wstrb = wb_wstrb; e.size = wb_size; end
    endcase
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Called mid-cycle in REQ. aok_lat: extra REQ cycles before addr_ok.
  // dok_lat: WAIT cycles up to and including data_ok (0 = same cycle as addr_ok).
  task automatic run_txn(input int aok_lat, input int dok_lat, input logic [31:0] rd, input string tag);
    exp_t e;
    logic is_rd;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    is_rd = (e.who == OWN_IR) || (e.who == OWN_DR);
    #1;
    chk({tag, ".mem_req"},   32'(mem_req),   32'd1);
    chk({tag, ".mem_wr"},    32'(mem_wr),    32'(e.wr));
    chk({tag, ".mem_addr"},  mem_addr,       e.addr);
    chk({tag, ".mem_wdata"}, mem_wdata,      e.wdata);
    chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'(e.wstrb));
    chk({tag, ".mem_size"},  32'(mem_size),  32'(e.size));
    for (int k = 0; k < aok_lat; k++) begin
      @(negedge clk);
      #1;
      chk({tag, ".req_hold"}, 32'(mem_req), 32'd1);
    end
    mem_addr_ok = 1'b1;
    if (dok_lat == 0) begin
      mem_data_ok = 1'b1;
      mem_rdata   = rd;
    end else begin
      for (int k = 1; k < dok_lat; k++) begin
        @(negedge clk);
        mem_addr_ok = 1'b0;
        #1;
        chk({tag, ".wait_req"},  32'(mem_req), 32'd0);
        chk({tag, ".wait_done"}, 32'({ir_done, dr_done, wb_ren}), 32'd0);
      end
      @(negedge clk);
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      mem_rdata   = rd;
    end
    #1;
    chk({tag, ".ir_done"}, 32'(ir_done), 32'(e.who == OWN_IR));
    chk({tag, ".dr_done"}, 32'(dr_done), 32'(e.who == OWN_DR));
    chk({tag, ".wb_ren"},  32'(wb_ren),  32'(e.who == OWN_WB));
    chk({tag, ".rdata"},   rdata,        is_rd ? rd : 32'd0);
    chk({tag, ".no_gnt"},  32'({ir_gnt, dr_gnt}), 32'd0);
    @(negedge clk);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  initial begin
    exp_t e;
    resetn = 1'b0;
    ir_req = 0; dr_req = 0; ir_addr = '0; dr_addr = '0; dr_size = '0;
    wb_empty = 1; wb_full = 0; wb_related = 0;
    wb_addr = '0; wb_wdata = '0; wb_wstrb = '0; wb_size = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.mem_req",  32'(mem_req), 32'd0);
    chk("rst.mem_wr",   32'(mem_wr),  32'd0);
    chk("rst.mem_addr", mem_addr,     32'd0);
    chk("rst.mem_misc", 32'({mem_size, mem_wstrb}), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.outs", 32'({ir_gnt, dr_gnt, ir_done, dr_done, wb_ren}), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // data_ok while idle is ignored
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("idle_dok.done", 32'({ir_done, dr_done, wb_ren}), 32'd0);
    chk("idle_dok.rdata", rdata, 32'd0);
    @(negedge clk);
    mem_data_ok = 1'b0; mem_rdata = '0;
    @(negedge clk);

    // Single instruction read, data_ok two cycles after addr_ok
    ir_req = 1; ir_addr = 32'h1FC0_0000;
    arb_step(OWN_IR, "single_ir");
    ir_req = 0;
    run_txn(0, 2, 32'h3C1D_0001, "single_ir");

    // No hazard: DR beats IR
    dr_req = 1; dr_addr = 32'h0000_2000; dr_size = 2'd1;
    ir_req = 1; ir_addr = 32'h1FC0_0004;
    arb_step(OWN_DR, "nohaz_dr");
    dr_req = 0;
    run_txn(1, 1, 32'h1111_2222, "nohaz_dr");
    arb_step(OWN_IR, "nohaz_ir");
    ir_req = 0;
    run_txn(0, 1, 32'h3333_4444, "nohaz_ir");

    // RAW hazard: related store drains before the load
    wb_empty = 0; wb_addr = 32'h8000_1000; wb_wdata = 32'hDEAD_BEEF; wb_wstrb = 4'b0011; wb_size = 2'd1;
    dr_req = 1; dr_addr = 32'h8000_1000; dr_size = 2'd2; wb_related = 1;
    arb_step(OWN_WB, "raw_wb");
    run_txn(0, 1, 32'h0, "raw_wb");
    wb_empty = 1; wb_related = 0;
    arb_step(OWN_DR, "raw_dr");
    dr_req = 0;
    run_txn(0, 1, 32'hCAFE_F00D, "raw_dr");

    // Full buffer beats an unrelated read; both use same-cycle addr/data ok
    wb_empty = 0; wb_full = 1; wb_addr = 32'h9000_0000; wb_wdata = 32'h0102_0304; wb_wstrb = 4'hF; wb_size = 2'd2;
    dr_req = 1; dr_addr = 32'h0000_3000; dr_size = 2'd0;
    arb_step(OWN_WB, "full_wb");
    run_txn(2, 0, 32'h0, "full_wb");
    wb_full = 0; wb_empty = 1;
    arb_step(OWN_DR, "full_dr");
    dr_req = 0;
    run_txn(0, 0, 32'h5555_AAAA, "full_dr");

    // IR beats a non-full write buffer
    wb_empty = 0; wb_addr = 32'hA000_0010; wb_wdata = 32'h7777_8888; wb_wstrb = 4'b1100; wb_size = 2'd1;
    ir_req = 1; ir_addr = 32'h1FC0_0008;
    arb_step(OWN_IR, "ir_wb_ir");
    ir_req = 0;
    run_txn(0, 1, 32'h2400_0001, "ir_wb_ir");
    arb_step(OWN_WB, "ir_wb_wb");
    run_txn(0, 1, 32'h0, "ir_wb_wb");
    wb_empty = 1;

    // Starvation: continuous data reads with a pending fetch
    dr_req = 1; dr_addr = 32'h0000_4000; dr_size = 2'd2;
    ir_req = 1; ir_addr = 32'h1FC0_0100;
    for (int i = 0; i < 8; i++) begin
      arb_step(OWN_DR, "starve_dr");
      run_txn(0, 0, 32'h100 + 32'(i), "starve_dr");
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    arb_step(OWN_IR, "starve_9th");
    ir_req = 0;
    run_txn(0, 0, 32'h0BAD_F00D, "starve_9th");
    arb_step(OWN_DR, "starve_dr_after");
    dr_req = 0;
    run_txn(0, 0, 32'h200, "starve_dr_after");
`else
    arb_step(OWN_DR, "starve_9th");
    dr_req = 0;
    run_txn(0, 0, 32'h108, "starve_9th");
    arb_step(OWN_IR, "starve_ir_late");
    ir_req = 0;
    run_txn(0, 0, 32'h0BAD_F00D, "starve_ir_late");
`endif

    // Asynchronous reset while in WAIT
    ir_req = 1; ir_addr = 32'h1FC0_0200;
    arb_step(OWN_IR, "rst_wait");
    ir_req = 0;
    e = exp_q.pop_front();
    #1;
    chk("rst_wait.mem_addr", mem_addr, e.addr);
    mem_addr_ok = 1;
    @(negedge clk);
    mem_addr_ok = 0;
    #1;
    resetn = 0;
    mem_data_ok = 1; mem_rdata = 32'h1234_5678;
    #1;
    chk("rst_wait.outs", 32'({ir_gnt, dr_gnt, ir_done, dr_done, wb_ren, mem_req, mem_wr}), 32'd0);
    chk("rst_wait.mem_addr0", mem_addr, 32'd0);
    chk("rst_wait.rdata", rdata, 32'd0);
    @(negedge clk);
    resetn = 1; mem_data_ok = 0; mem_rdata = '0;
    @(negedge clk);
    dr_req = 1; dr_addr = 32'h0000_5000; dr_size = 2'd2;
    arb_step(OWN_DR, "post_rst");
    dr_req = 0;
    run_txn(0, 1, 32'h9999_0000, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
